// File: rtl/sc_muxrr_pkg.sv
// Shared definitions for the arbitrating multiplexer family: mode encoding
// and the rotated-priority search used by the round-robin picker.
package sc_muxrr_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int unsigned MAX_CHANNELS = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... modulo numCh.
    // ptr is always below numCh, so one conditional subtraction wraps it.
    function automatic pick_t rotPick(input logic [MAX_CHANNELS-1:0] req,
                                      input logic [3:0] ptr,
                                      input int unsigned numCh);
        pick_t      res;
        logic [4:0] k;
        res = '0;
        for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
            k = 5'(ptr) + 5'(i);
            if (k >= 5'(numCh)) begin
                k = k - 5'(numCh);
            end
            if ((i < numCh) && !res.found && req[k[3:0]]) begin
                res.found = 1'b1;
                res.idx   = k[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational rotated-priority picker: returns the first requesting
// channel at or after the pointer, plus a flag saying whether any won.
module sc_rr_picker
    import sc_muxrr_pkg::*;
#(
    parameter int unsigned NUMBER_CHANNELS    = 8,
    parameter int unsigned NUMBER_SELECTWIDTH = 3
) (
    input  logic [NUMBER_CHANNELS-1:0]    request,
    input  logic [NUMBER_SELECTWIDTH-1:0] pointer,
    output logic [NUMBER_SELECTWIDTH-1:0] winner,
    output logic                          found
);

    pick_t pick;

    // Rotated-priority search over the request vector.
    always_comb begin
        pick = rotPick(MAX_CHANNELS'(request), 4'(pointer), NUMBER_CHANNELS);
    end

    assign winner = NUMBER_SELECTWIDTH'(pick.idx);
    assign found  = pick.found;

endmodule

// File: rtl/sc_muxrr.sv
// N-channel arbitrating multiplexer: fixed-select or round-robin winner,
// per-channel ack, one-deep registered output with valid/ready.
module sc_muxrr
    import sc_muxrr_pkg::*;
#(
    parameter int unsigned NUMBER_DATAWIDTH   = 8,
    parameter int unsigned NUMBER_CHANNELS    = 8,
    parameter int unsigned NUMBER_SELECTWIDTH = 3
) (
    input  logic                                        SC_MUXRR_CLOCK_50,
    input  logic                                        SC_MUXRR_RESET_InHigh,
    input  logic                                        SC_MUXRR_mode_In,
    input  logic [NUMBER_SELECTWIDTH-1:0]               SC_MUXRR_select_InBUS,
    input  logic [NUMBER_CHANNELS-1:0]                  SC_MUXRR_valid_InBUS,
    input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] SC_MUXRR_data_InBUS,
    output logic [NUMBER_CHANNELS-1:0]                  SC_MUXRR_ack_OutBUS,
    input  logic                                        SC_MUXRR_ready_In,
    output logic                                        SC_MUXRR_valid_Out,
    output logic [NUMBER_DATAWIDTH-1:0]                 SC_MUXRR_z_Out,
    output logic [NUMBER_SELECTWIDTH-1:0]               SC_MUXRR_channel_OutBUS
);

    logic [NUMBER_SELECTWIDTH-1:0] ptr;
    logic [NUMBER_SELECTWIDTH-1:0] rrIdx;
    logic                          rrFound;
    logic                          fixedFound;
    logic                          winFound;
    logic [NUMBER_SELECTWIDTH-1:0] winIdx;
    logic [NUMBER_DATAWIDTH-1:0]   winData;
    logic                          load;
    logic                          grant;
    logic                          validReg;
    logic [NUMBER_DATAWIDTH-1:0]   zReg;
    logic [NUMBER_SELECTWIDTH-1:0] chReg;

    sc_rr_picker #(
        .NUMBER_CHANNELS   (NUMBER_CHANNELS),
        .NUMBER_SELECTWIDTH(NUMBER_SELECTWIDTH)
    ) uPicker (
        .request(SC_MUXRR_valid_InBUS),
        .pointer(ptr),
        .winner (rrIdx),
        .found  (rrFound)
    );

    // Fixed-mode candidate; an out-of-range select matches no channel.
    always_comb begin
        fixedFound = 1'b0;
        for (int unsigned i = 0; i < NUMBER_CHANNELS; i++) begin
            if ((SC_MUXRR_select_InBUS == NUMBER_SELECTWIDTH'(i)) && SC_MUXRR_valid_InBUS[i]) begin
                fixedFound = 1'b1;
            end
        end
    end

    // Winner selection by mode, plus load/grant qualification.
    always_comb begin
        if (SC_MUXRR_mode_In == MODE_RR) begin
            winFound = rrFound;
            winIdx   = rrIdx;
        end else begin
            winFound = fixedFound;
            winIdx   = SC_MUXRR_select_InBUS;
        end
        load  = !validReg || SC_MUXRR_ready_In;
        grant = load && winFound && !SC_MUXRR_RESET_InHigh;
    end

    // Ack decode and winning data word.
    always_comb begin
        SC_MUXRR_ack_OutBUS = '0;
        winData             = '0;
        for (int unsigned i = 0; i < NUMBER_CHANNELS; i++) begin
            if (winIdx == NUMBER_SELECTWIDTH'(i)) begin
                winData = SC_MUXRR_data_InBUS[i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
                if (grant) begin
                    SC_MUXRR_ack_OutBUS[i] = 1'b1;
                end
            end
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge SC_MUXRR_CLOCK_50) begin
        if (SC_MUXRR_RESET_InHigh) begin
            validReg <= 1'b0;
            zReg     <= '0;
            chReg    <= '0;
            ptr      <= '0;
        end else begin
            if (load) begin
                if (winFound) begin
                    validReg <= 1'b1;
                    zReg     <= winData;
                    chReg    <= winIdx;
                end else begin
                    validReg <= 1'b0;
                end
            end
            if (grant && (SC_MUXRR_mode_In == MODE_RR)) begin
                if (winIdx == NUMBER_SELECTWIDTH'(NUMBER_CHANNELS - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= winIdx + NUMBER_SELECTWIDTH'(1);
                end
            end
        end
    end

    assign SC_MUXRR_valid_Out      = validReg;
    assign SC_MUXRR_z_Out          = zReg;
    assign SC_MUXRR_channel_OutBUS = chReg;

endmodule

// File: tb/tb_sc_muxrr.sv
// Scoreboard bench for sc_muxrr: stimulus pushes expected words, a monitor
// pops them as the output stage hands them off, and also checks acks.
module tb_sc_muxrr;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] c;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  valid;
    logic [63:0] dataBus;
    logic [7:0]  ack;
    logic        ready;
    logic        validOut;
    logic [7:0]  zOut;
    logic [2:0]  chOut;

    word_t       sbq[$];
    logic [7:0]  expAck;
    bit          chkAck, chkReset, chkIdle, chkHold, chkEmpty;
    logic [7:0]  holdD;
    logic [2:0]  holdC;
    int          checkCnt = 0;
    int          passCnt  = 0;

    always #5 clk = ~clk;

    sc_muxrr #(
        .NUMBER_DATAWIDTH  (8),
        .NUMBER_CHANNELS   (8),
        .NUMBER_SELECTWIDTH(3)
    ) dut (
        .SC_MUXRR_CLOCK_50      (clk),
        .SC_MUXRR_RESET_InHigh  (rst),
        .SC_MUXRR_mode_In       (mode),
        .SC_MUXRR_select_InBUS  (sel),
        .SC_MUXRR_valid_InBUS   (valid),
        .SC_MUXRR_data_InBUS    (dataBus),
        .SC_MUXRR_ack_OutBUS    (ack),
        .SC_MUXRR_ready_In      (ready),
        .SC_MUXRR_valid_Out     (validOut),
        .SC_MUXRR_z_Out         (zOut),
        .SC_MUXRR_channel_OutBUS(chOut)
    );

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        word_t w;
        if (chkAck) begin
            checkCnt++;
            if (ack === expAck) passCnt++;
            else $display("FAIL ack: got %b want %b at %0t", ack, expAck, $time);
        end
        if (chkReset) begin
            checkCnt++;
            if (validOut === 1'b0 && zOut === 8'h00 && chOut === 3'd0) passCnt++;
            else $display("FAIL reset_state: got v=%b z=%h ch=%0d want v=0 z=00 ch=0", validOut, zOut, chOut);
        end
        if (chkIdle) begin
            checkCnt++;
            if (validOut === 1'b0) passCnt++;
            else $display("FAIL idle: got valid_Out=%b want 0 at %0t", validOut, $time);
        end
        if (chkHold) begin
            checkCnt++;
            if (validOut === 1'b1 && zOut === holdD && chOut === holdC) passCnt++;
            else $display("FAIL hold: got v=%b z=%h ch=%0d want v=1 z=%h ch=%0d", validOut, zOut, chOut, holdD, holdC);
        end
        if (validOut === 1'b1 && ready === 1'b1 && rst === 1'b0) begin
            checkCnt++;
            if (sbq.size() == 0) begin
                $display("FAIL word: got z=%h ch=%0d want no word (queue empty)", zOut, chOut);
            end else begin
                w = sbq.pop_front();
                if (zOut === w.d && chOut === w.c) passCnt++;
                else $display("FAIL word: got z=%h ch=%0d want z=%h ch=%0d", zOut, chOut, w.d, w.c);
            end
        end
        if (chkEmpty) begin
            checkCnt++;
            if (sbq.size() == 0) passCnt++;
            else $display("FAIL drain: got %0d queued words want 0", sbq.size());
        end
    end

    // One cycle of stimulus: apply inputs, record expectations, step past the edge.
    task automatic cyc(input logic r, input logic m, input logic [2:0] s, input logic [7:0] v,
                       input logic rdy, input logic [7:0] eAck,
                       input bit push, input logic [7:0] pd, input logic [2:0] pc);
        rst    = r;
        mode   = m;
        sel    = s;
        valid  = v;
        ready  = rdy;
        expAck = eAck;
        chkAck = 1'b1;
        if (push) sbq.push_back('{d: pd, c: pc});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ch7..ch0
        dataBus  = {8'h3C, 8'h66, 8'h55, 8'h44, 8'hA5, 8'h11, 8'h21, 8'h10};
        chkReset = 1'b1;
        chkIdle  = 1'b0;
        chkHold  = 1'b0;
        chkEmpty = 1'b0;
        holdD    = 8'h00;
        holdC    = 3'd0;

        // Reset for two edges with every channel requesting.
        cyc(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 0);
        cyc(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 0);
        // Release: first RR grant is channel 0.
        cyc(0, 1, 0, 8'hFF, 1, 8'h01, 1, 8'h10, 3'd0);
        chkReset = 1'b0;

        // Fixed mode: select 3, then 7, then an unrequested select.
        cyc(0, 0, 3, 8'hFF, 1, 8'h08, 1, 8'hA5, 3'd3);
        cyc(0, 0, 7, 8'hFF, 1, 8'h80, 1, 8'h3C, 3'd7);
        cyc(0, 0, 2, 8'h01, 1, 8'h00, 0, 0, 0);
        chkIdle = 1'b1;
        cyc(0, 0, 2, 8'h01, 1, 8'h00, 0, 0, 0);
        chkIdle = 1'b0;

        // Reset to put ptr at 0, then RR wrap over channels 0,2,7.
        cyc(1, 1, 0, 8'h85, 1, 8'h00, 0, 0, 0);
        chkReset = 1'b1;
        cyc(0, 1, 0, 8'h85, 1, 8'h01, 1, 8'h10, 3'd0);
        chkReset = 1'b0;
        cyc(0, 1, 0, 8'h85, 1, 8'h04, 1, 8'h11, 3'd2);
        cyc(0, 1, 0, 8'h85, 1, 8'h80, 1, 8'h3C, 3'd7);
        cyc(0, 1, 0, 8'h85, 1, 8'h01, 1, 8'h10, 3'd0);
        cyc(0, 1, 0, 8'h85, 1, 8'h04, 1, 8'h11, 3'd2);
        cyc(0, 1, 0, 8'h85, 1, 8'h80, 1, 8'h3C, 3'd7);

        // Backpressure after a channel-2 grant; 7 loads on the ready edge.
        cyc(0, 1, 0, 8'h85, 1, 8'h01, 1, 8'h10, 3'd0);
        cyc(0, 1, 0, 8'h85, 1, 8'h04, 1, 8'h11, 3'd2);
        holdD   = 8'h11;
        holdC   = 3'd2;
        chkHold = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h85, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 0, 8'h85, 1, 8'h80, 1, 8'h3C, 3'd7);
        chkHold = 1'b0;

        // Grant channel 4 so ptr becomes 5; that word is dropped by reset.
        cyc(0, 1, 0, 8'h10, 1, 8'h10, 0, 0, 0);
        holdD   = 8'h44;
        holdC   = 3'd4;
        chkHold = 1'b1;
        cyc(1, 1, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        chkHold  = 1'b0;
        chkReset = 1'b1;
        // ptr back at 0: channels 3 and 5 request, 3 must win.
        cyc(0, 1, 0, 8'h28, 1, 8'h08, 1, 8'hA5, 3'd3);
        chkReset = 1'b0;
        cyc(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        chkIdle  = 1'b1;
        chkEmpty = 1'b1;
        cyc(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        chkIdle  = 1'b0;
        chkEmpty = 1'b0;
        chkAck   = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
